// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : writeback_stage
// Brief    : MEM/WB pipeline register, result select/extend, single write
//            strobe per instruction and same-cycle bypass to decode.
// Revision : 1.0 - initial release
// ============================================================================
module writeback_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_instruction,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_rdata,
  input  logic [DATA_W-1:0] in_pc_plus4,
  input  logic [1:0]        in_memtoreg,
  input  logic [1:0]        in_mem_size,
  input  logic              in_mem_unsigned,
  input  logic              in_regwrite,
  input  logic [1:0]        in_regdst,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  output logic [DATA_W-1:0] instruction,
  output logic [1:0]        regdst,
  output logic [DATA_W-1:0] write_data,
  output logic              regwrite,
  output logic [4:0]        wb_dest,
  output logic              fwd_rs_hit,
  output logic              fwd_rt_hit,
  output logic [DATA_W-1:0] fwd_data
);

  logic              r_valid;
  logic              r_written;
  logic [DATA_W-1:0] r_instr;
  logic [DATA_W-1:0] r_alu;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_pc4;
  logic [1:0]        r_memtoreg;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic              r_regwrite;
  logic [1:0]        r_regdst;

  logic              w_live;
  logic              w_strobe;
  logic [4:0]        w_dest;
  logic [15:0]       w_half;
  logic [7:0]        w_byte;
  logic [DATA_W-1:0] w_load;
  logic [DATA_W-1:0] w_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_written  <= 1'b0;
      r_instr    <= '0;
      r_alu      <= '0;
      r_rdata    <= '0;
      r_pc4      <= '0;
      r_memtoreg <= 2'b00;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_regwrite <= 1'b0;
      r_regdst   <= 2'b00;
    end else if (flush) begin
      r_valid   <= 1'b0;
      r_written <= 1'b0;
    end else if (stall) begin
      // Remember the strobe so a held instruction is written only once.
      if (w_strobe) begin
        r_written <= 1'b1;
      end
    end else begin
      r_valid    <= in_valid;
      r_written  <= 1'b0;
      r_instr    <= in_instruction;
      r_alu      <= in_alu_result;
      r_rdata    <= in_mem_rdata;
      r_pc4      <= in_pc_plus4;
      r_memtoreg <= in_memtoreg;
      r_size     <= in_mem_size;
      r_unsigned <= in_mem_unsigned;
      r_regwrite <= in_regwrite;
      r_regdst   <= in_regdst;
    end
  end

  always_comb begin
    w_dest = r_instr[20:16];
    case (r_regdst)
      2'b01:   w_dest = r_instr[15:11];
      2'b10:   w_dest = 5'd31;
      default: w_dest = r_instr[20:16];
    endcase
  end

  // $0 is not protected inside register_file, so it is filtered here.
  assign w_live   = r_valid & r_regwrite & (w_dest != 5'd0);
  assign w_strobe = w_live & ~r_written;

  // Big-endian lane select: lowest address maps to the most significant lane.
  assign w_half = r_alu[1] ? r_rdata[15:0] : r_rdata[31:16];

  always_comb begin
    w_byte = r_rdata[31:24];
    case (r_alu[1:0])
      2'b01:   w_byte = r_rdata[23:16];
      2'b10:   w_byte = r_rdata[15:8];
      2'b11:   w_byte = r_rdata[7:0];
      default: w_byte = r_rdata[31:24];
    endcase
  end

  always_comb begin
    w_load = r_rdata;
    case (r_size)
      2'b01:   w_load = {{(DATA_W-16){w_half[15] & ~r_unsigned}}, w_half};
      2'b10:   w_load = {{(DATA_W-8){w_byte[7] & ~r_unsigned}}, w_byte};
      default: w_load = r_rdata;
    endcase
  end

  always_comb begin
    w_wdata = r_alu;
    case (r_memtoreg)
      2'b01:   w_wdata = w_load;
      2'b10:   w_wdata = r_pc4;
      default: w_wdata = r_alu;
    endcase
  end

  assign instruction = r_instr;
  assign regdst      = r_regdst;
  assign write_data  = w_wdata;
  assign regwrite    = w_strobe;
  assign wb_dest     = w_dest;
  assign fwd_rs_hit  = w_live & (rs_addr == w_dest);
  assign fwd_rt_hit  = w_live & (rt_addr == w_dest);
  assign fwd_data    = w_wdata;

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_stage
// Brief    : Scoreboard bench for writeback_stage with a record-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, stall, flush;
  logic [31:0] in_instruction, in_alu_result, in_mem_rdata, in_pc_plus4;
  logic [1:0]  in_memtoreg, in_mem_size, in_regdst;
  logic        in_mem_unsigned, in_regwrite;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] instruction, write_data, fwd_data;
  logic [1:0]  regdst;
  logic        regwrite, fwd_rs_hit, fwd_rt_hit;
  logic [4:0]  wb_dest;

  writeback_stage #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .in_instruction(in_instruction), .in_alu_result(in_alu_result),
    .in_mem_rdata(in_mem_rdata), .in_pc_plus4(in_pc_plus4),
    .in_memtoreg(in_memtoreg), .in_mem_size(in_mem_size),
    .in_mem_unsigned(in_mem_unsigned), .in_regwrite(in_regwrite),
    .in_regdst(in_regdst), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .instruction(instruction), .regdst(regdst), .write_data(write_data),
    .regwrite(regwrite), .wb_dest(wb_dest), .fwd_rs_hit(fwd_rs_hit),
    .fwd_rt_hit(fwd_rt_hit), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    bit          valid;
    bit          rw;
    logic [4:0]  dest;
    logic [31:0] data;
    logic [31:0] instr;
    logic [1:0]  regdst;
  } rec_t;

  wr_t  sbq[$];
  rec_t cur;
  int   total = 0;
  int   bad   = 0;

  function automatic logic [31:0] make_instr(input logic [4:0] rt, input logic [4:0] rd);
    return {6'd0, 5'd1, rt, rd, 5'd0, 6'h21};
  endfunction

  function automatic logic [4:0] dest_of(input logic [31:0] ins, input logic [1:0] rd_sel);
    if (rd_sel == 2'b01) return ins[15:11];
    if (rd_sel == 2'b10) return 5'd31;
    return ins[20:16];
  endfunction

  // Result from the architectural rules: shift the addressed lane down, then extend.
  function automatic logic [31:0] result_of(input logic [1:0] m2r, input logic [1:0] sz,
                                            input logic uns, input logic [31:0] alu,
                                            input logic [31:0] rdata, input logic [31:0] pc4);
    logic [31:0] v;
    int          w;
    if (m2r == 2'b10) return pc4;
    if (m2r != 2'b01) return alu;
    if (sz == 2'b01) begin
      w = 16;
      v = (rdata >> (alu[1] ? 0 : 16)) & 32'hFFFF;
    end else if (sz == 2'b10) begin
      w = 8;
      v = (rdata >> (8 * (3 - int'(alu[1:0])))) & 32'hFF;
    end else begin
      return rdata;
    end
    if (!uns && v >= (32'd1 << (w - 1))) v = v - (32'd1 << w);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [31:0] ins, input logic [31:0] alu,
                        input logic [31:0] rdata, input logic [31:0] pc4, input logic [1:0] m2r,
                        input logic [1:0] sz, input logic uns, input logic rw, input logic [1:0] rd_sel);
    in_valid = v; in_instruction = ins; in_alu_result = alu; in_mem_rdata = rdata;
    in_pc_plus4 = pc4; in_memtoreg = m2r; in_mem_size = sz; in_mem_unsigned = uns;
    in_regwrite = rw; in_regdst = rd_sel;
  endtask

  task automatic check_model();
    bit live;
    live = cur.valid && cur.rw && (cur.dest != 5'd0);
    chk("fwd_rs_hit", {31'd0, fwd_rs_hit}, {31'd0, live && (rs_addr == cur.dest)});
    chk("fwd_rt_hit", {31'd0, fwd_rt_hit}, {31'd0, live && (rt_addr == cur.dest)});
    if (cur.valid) begin
      chk("write_data", write_data, cur.data);
      chk("fwd_data", fwd_data, cur.data);
      chk("wb_dest", {27'd0, wb_dest}, {27'd0, cur.dest});
      chk("instruction", instruction, cur.instr);
    end
  endtask

  // One clock: predict acceptance from the driven inputs, advance, then check.
  task automatic tick(input logic st, input logic fl);
    rec_t  nxt;
    wr_t   w;
    stall = st;
    flush = fl;
    nxt.valid  = in_valid;
    nxt.rw     = in_regwrite;
    nxt.dest   = dest_of(in_instruction, in_regdst);
    nxt.data   = result_of(in_memtoreg, in_mem_size, in_mem_unsigned, in_alu_result,
                           in_mem_rdata, in_pc_plus4);
    nxt.instr  = in_instruction;
    nxt.regdst = in_regdst;
    if (!reset && !fl && !st && in_valid && in_regwrite && nxt.dest != 5'd0) begin
      w.dest = nxt.dest;
      w.data = nxt.data;
      sbq.push_back(w);
    end
    @(posedge clk);
    if (reset || fl) cur.valid = 1'b0;
    else if (!st)    cur = nxt;
    #2;
    check_model();
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (regwrite === 1'b1) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL strobe_unexpected got dest=%0d data=%h exp none", wb_dest, write_data);
      end else begin
        wr_t e;
        e = sbq.pop_front();
        if (wb_dest !== e.dest || write_data !== e.data) begin
          bad++;
          $display("FAIL strobe got dest=%0d data=%h exp dest=%0d data=%h",
                   wb_dest, write_data, e.dest, e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    cur = '{valid: 1'b0, rw: 1'b0, dest: 5'd0, data: 32'd0, instr: 32'd0, regdst: 2'd0};
    reset = 1'b1; stall = 1'b0; flush = 1'b0; rs_addr = 5'd0; rt_addr = 5'd0;
    set_in(1, make_instr(5'd4, 5'd3), 32'hDEAD, 32'h0, 32'h0, 2'b00, 2'b00, 0, 1, 2'b01);
    tick(0, 0);
    tick(0, 0);
    chk("rst_regwrite", {31'd0, regwrite}, 32'd0);
    chk("rst_write_data", write_data, 32'd0);
    chk("rst_instruction", instruction, 32'd0);
    chk("rst_regdst", {30'd0, regdst}, 32'd0);
    chk("rst_hits", {30'd0, fwd_rs_hit, fwd_rt_hit}, 32'd0);
    reset = 1'b0;

    // addu $3 then addu $5
    rs_addr = 5'd3;
    set_in(1, make_instr(5'd4, 5'd3), 32'h0000_0777, 32'h0, 32'h0, 2'b00, 2'b00, 0, 1, 2'b01);
    tick(0, 0);
    chk("addu3_regwrite", {31'd0, regwrite}, 32'd1);
    rs_addr = 5'd5;
    set_in(1, make_instr(5'd6, 5'd5), 32'h0000_1234, 32'h0, 32'h0, 2'b00, 2'b00, 0, 1, 2'b01);
    tick(0, 0);
    chk("addu5_regwrite", {31'd0, regwrite}, 32'd1);
    chk("addu5_dest", {27'd0, wb_dest}, 32'd5);
    chk("addu5_data", write_data, 32'h0000_1234);

    // Sub-word loads
    set_in(1, make_instr(5'd8, 5'd0), 32'h0000_1001, 32'h1182_3344, 32'h0, 2'b01, 2'b10, 0, 1, 2'b00);
    tick(0, 0);
    chk("lb_signed", write_data, 32'hFFFF_FF82);
    set_in(1, make_instr(5'd8, 5'd0), 32'h0000_1001, 32'h1182_3344, 32'h0, 2'b01, 2'b10, 1, 1, 2'b00);
    tick(0, 0);
    chk("lbu", write_data, 32'h0000_0082);
    set_in(1, make_instr(5'd8, 5'd0), 32'h0000_1002, 32'h1182_3344, 32'h0, 2'b01, 2'b01, 0, 1, 2'b00);
    tick(0, 0);
    chk("lh_off2", write_data, 32'h0000_3344);

    // jal
    set_in(1, make_instr(5'd2, 5'd9), 32'h0000_0055, 32'h0, 32'h0040_0008, 2'b10, 2'b00, 0, 1, 2'b10);
    tick(0, 0);
    chk("jal_dest", {27'd0, wb_dest}, 32'd31);
    chk("jal_data", write_data, 32'h0040_0008);

    // addu $7 held for three stall cycles
    rs_addr = 5'd7;
    set_in(1, make_instr(5'd1, 5'd7), 32'h0000_0707, 32'h0, 32'h0, 2'b00, 2'b00, 0, 1, 2'b01);
    tick(0, 0);
    chk("stall_c0_rw", {31'd0, regwrite}, 32'd1);
    chk("stall_c0_hit", {31'd0, fwd_rs_hit}, 32'd1);
    set_in(1, make_instr(5'd1, 5'd12), 32'h0000_0C0C, 32'h0, 32'h0, 2'b00, 2'b00, 0, 1, 2'b01);
    for (int i = 1; i <= 3; i++) begin
      tick(1, 0);
      chk("stall_rw", {31'd0, regwrite}, 32'd0);
      chk("stall_hit", {31'd0, fwd_rs_hit}, 32'd1);
    end

    // Destination $0 is never written nor forwarded
    rs_addr = 5'd0;
    set_in(1, make_instr(5'd1, 5'd0), 32'h0000_0BAD, 32'h0, 32'h0, 2'b00, 2'b00, 0, 1, 2'b01);
    tick(0, 0);
    chk("r0_regwrite", {31'd0, regwrite}, 32'd0);
    chk("r0_hit", {31'd0, fwd_rs_hit}, 32'd0);

    // Flush while stalled, flush on acceptance, reset while stalled
    rs_addr = 5'd9;
    set_in(1, make_instr(5'd1, 5'd9), 32'h0000_0909, 32'h0, 32'h0, 2'b00, 2'b00, 0, 1, 2'b01);
    tick(0, 0);
    tick(1, 1);
    chk("flush_rw", {31'd0, regwrite}, 32'd0);
    chk("flush_hit", {31'd0, fwd_rs_hit}, 32'd0);
    rs_addr = 5'd10;
    set_in(1, make_instr(5'd1, 5'd10), 32'h0000_0A0A, 32'h0, 32'h0, 2'b00, 2'b00, 0, 1, 2'b01);
    tick(0, 1);
    chk("flush_accept_hit", {31'd0, fwd_rs_hit}, 32'd0);
    rs_addr = 5'd11;
    set_in(1, make_instr(5'd1, 5'd11), 32'h0000_0B0B, 32'h0, 32'h0, 2'b00, 2'b00, 0, 1, 2'b01);
    tick(0, 0);
    tick(1, 0);
    reset = 1'b1;
    tick(1, 0);
    reset = 1'b0;
    chk("reset_stall_hit", {31'd0, fwd_rs_hit}, 32'd0);
    tick(0, 0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      logic [1:0]  rd_sel;
      ins    = $urandom;
      rd_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) ins[15:11] = 5'd0;
      set_in(1'($urandom_range(0, 9) != 0), ins, $urandom, $urandom, $urandom,
             2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) != 0), rd_sel);
      rs_addr = $urandom_range(0, 1) ? dest_of(ins, rd_sel) : 5'($urandom);
      rt_addr = $urandom_range(0, 1) ? cur.dest : 5'($urandom);
      tick(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0));
    end

    in_valid = 1'b0;
    tick(0, 0);
    tick(0, 0);
    chk("sb_drained", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
